elastic_buffer: RTL and testbench
=================================

# elastic_buffer

Clocked, parametrised successor to the single-slot channel buffer: a DEPTH-entry FIFO of WIDTH-bit tokens with valid/ready handshakes on both sides, an occupancy count and a synchronous flush. It sits between producer and consumer stages, decoupling their stalls while preserving token order. Ready signals never depend combinationally on the opposite side, so chains of buffers add no long combinational ready paths.

## Interface
- WIDTH, 8, token width in bits (>=1)
- DEPTH, 4, number of storage slots (power of two, >=2)
- CW, $clog2(DEPTH+1), width of count output (derived, not overridden)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_valid  in  1  producer offers in_data
- in_ready  out  1  buffer can accept this cycle
- in_data  in  WIDTH  producer token
- out_valid  out  1  token available at out_data
- out_ready  in  1  consumer takes token this cycle
- out_data  out  WIDTH  oldest stored token
- flush  in  1  synchronous discard of all stored tokens
- count  out  CW  number of stored tokens, 0..DEPTH

## Operation
- Storage: DEPTH-entry array, write pointer wr_ptr and read pointer rd_ptr (log2(DEPTH) bits each, wrap naturally modulo DEPTH), count register.
- Push = in_valid & in_ready at rising edge: mem[wr_ptr] <= in_data, wr_ptr+1.
- Pop = out_valid & out_ready at rising edge: rd_ptr+1.
- count next = count + push - pop; simultaneous push and pop leaves count unchanged.
- in_ready = !reset & !flush & (count != DEPTH); no dependence on out_ready (full buffer refuses push even when a pop occurs the same cycle).
- out_valid = (count != 0); out_data = mem[rd_ptr] when out_valid, else all zeros.
- Order: strict FIFO; no token duplicated or dropped except by flush/reset.
- flush: at edge, count, wr_ptr, rd_ptr <= 0; any push/pop that cycle is ignored (in_ready already 0; pop discarded with contents).
- reset: highest priority, same effect as flush; array contents need not be cleared (never observable since out_data masked when empty).
- in_valid low with in_ready high: no state change. Protocol rule for producer/consumer: once valid asserted, data held stable until handshake; buffer itself obeys this on out side (out_data stable while out_valid & !out_ready, unless flush/reset).

## Timing
- Reset values (cycle after reset edge): count=0, out_valid=0, out_data=0, in_ready=1 (0 while reset asserted).
- Latency: token pushed at edge k is visible at out_data/out_valid from edge k onward (cycle k+1); no same-cycle bypass from in_data to out_data.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Full (count=DEPTH): in_ready=0 in the cycle following the edge that filled it; re-asserts the cycle after the first pop.
- Empty with push and out_ready high: no pop that edge; token popped no earlier than next edge.
- Pointer wrap: wr_ptr/rd_ptr DEPTH-1 -> 0 with no bubble.
- Reset or flush mid-stream: takes effect at that edge; next cycle is empty state regardless of prior occupancy.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0, out_data=0; release -> in_ready=1 next cycle.
- Fill/drain, DEPTH=4: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 4, in_ready=0, 5th offer 0x55 refused; then out_ready=1 -> 0x11..0x44 in order, count to 0, out_valid=0.
- Streaming with wrap: 20 consecutive tokens 0..19, out_ready=1 throughout -> output 0..19 one per cycle after 1-cycle latency, count steady at 1, pointers wrap 5 times with no gap.
- Full plus simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop occurs, push refused, count 3; next cycle push accepted, count back to 4.
- Random backpressure: in_valid and out_ready each 50% random for 1000 cycles -> scoreboard order exact, count always equals pushes minus pops, out_data stable while stalled.
- Flush mid-operation: count=3, assert flush with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0; subsequent push 0xA5 emerges as the only token.

Source files
------------

// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready FIFO with occupancy count and synchronous flush; one-cycle latency, no bypass.
// in_ready depends only on local state (never on out_ready), so a full buffer refuses input even while popping.
module elastic_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = !reset && !flush && (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Stale array contents are hidden whenever the buffer is empty.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // push is already gated by reset/flush through in_ready.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Scoreboard bench for elastic_buffer: a queue model predicts ready/valid/data/count every cycle.
module tb_elastic_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] sb [$];

  elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge and advance one full cycle.
  task automatic drive(input logic vld, input logic [WIDTH-1:0] dat, input logic ordy,
                       input logic fl, input logic rst);
    in_valid  = vld;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  // Predict outputs from the model, then advance the model by the handshakes of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy;
      logic exp_vld;
      exp_rdy = !reset && !flush && (sb.size() != DEPTH);
      exp_vld = (sb.size() != 0);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_vld));
      chk("count", 32'(count), 32'(sb.size()));
      chk("out_data", 32'(out_data), exp_vld ? 32'(sb[0]) : 32'h0);
      if (reset || flush) begin
        sb.delete();
      end else begin
        if (exp_vld && out_ready) void'(sb.pop_front());
        if (exp_rdy && in_valid) sb.push_back(in_data);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] rd;
    in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 32'(count), 32'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_release_rdy", 32'(in_ready), 32'h1);

    // Fill, offer a fifth token, then drain.
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'h4);
    chk("full_head", 32'(out_data), 32'h11);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drained_vld", 32'(out_valid), 32'h0);

    // Streaming through five pointer wraps.
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    chk("stream_count", 32'(count), 32'h1);
    chk("stream_last", 32'(out_data), 32'd19);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Full with simultaneous pop: push refused, then accepted next cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
    chk("fullpop_count", 32'(count), 32'h3);
    drive(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    chk("refill_count", 32'(count), 32'h4);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random backpressure with a protocol-abiding producer.
    rd = 8'($urandom);
    for (int i = 0; i < 1000; i++) begin
      logic v;
      if (in_valid && !in_ready) begin
        v = 1'b1;
      end else begin
        v  = 1'($urandom_range(0, 1));
        rd = 8'($urandom);
      end
      drive(v, rd, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush with three tokens held, push and pop both offered.
    drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    chk("preflush_count", 32'(count), 32'h3);
    drive(1'b1, 8'hC4, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_vld", 32'(out_valid), 32'h0);
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("postflush_data", 32'(out_data), 32'hA5);
    chk("postflush_count", 32'(count), 32'h1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("postflush_empty", 32'(out_valid), 32'h0);

    // Mid-stream reset.
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h5B, 1'b0, 1'b0, 1'b1);
    chk("midrst_count", 32'(count), 32'h0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
